// File: rtl/ram_wr_ctrl_if.sv
// ram_wr_ctrl_if
//   Bundles the board-facing signals of the RAM write controller.
//   master : board / stimulus side (drives keys, switches, test hook)
//   slave  : ram_wr_ctrl (drives readback data, status and 7-segment digits)
//   Signals:
//     wr_key_n, rd_key_n  active-low push buttons, asynchronous to clk
//     addr_in, data_in    switch-selected address and write data
//     wr_inhibit          test hook: suppresses the RAM write enable so a
//                         write completes with a forced readback mismatch;
//                         tie low in normal use
//     data_out            last word read from RAM
//     busy, done          controller busy level / one-cycle completion pulse
//     wr_err, wr_count    readback mismatch flag / completed write counter
//     HEX0..HEX3          active-low segments a..g, index 0 = segment a
interface ram_wr_ctrl_if #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 5
);
   logic                     wr_key_n;
   logic                     rd_key_n;
   logic [ADDRESS_WIDTH-1:0] addr_in;
   logic [DATA_WIDTH-1:0]    data_in;
   logic                     wr_inhibit;
   logic [DATA_WIDTH-1:0]    data_out;
   logic                     busy;
   logic                     done;
   logic                     wr_err;
   logic [7:0]               wr_count;
   logic [0:6]               HEX0;
   logic [0:6]               HEX1;
   logic [0:6]               HEX2;
   logic [0:6]               HEX3;

   modport master (
      output wr_key_n, rd_key_n, addr_in, data_in, wr_inhibit,
      input  data_out, busy, done, wr_err, wr_count, HEX0, HEX1, HEX2, HEX3
   );

   modport slave (
      input  wr_key_n, rd_key_n, addr_in, data_in, wr_inhibit,
      output data_out, busy, done, wr_err, wr_count, HEX0, HEX1, HEX2, HEX3
   );
endinterface

// File: rtl/ram_wr_ctrl.sv
// ram_wr_ctrl
//   Push-button controller for an on-chip synchronous RAM. A debounced write
//   press stores the switch word at the switch address, reads it back and
//   flags a mismatch; a debounced read press just reads an address. The last
//   word read is held on data_out and shown on four 7-segment digits.
//   Ports:
//     clk  50 MHz system clock, rising edge
//     rst  synchronous active-high reset (RAM contents are kept)
//     bus  ram_wr_ctrl_if.slave: keys, switches, status, HEX digits
module ram_wr_ctrl #(
   parameter int DATA_WIDTH      = 16,
   parameter int ADDRESS_WIDTH   = 5,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic         clk,
   input logic         rst,
   ram_wr_ctrl_if.slave bus
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, WRITE, RB_ADDR, RB_CHECK, READ, READ_WAIT
   } state_t;

   // Active-low glyphs, segment a in the leftmost bit.
   function automatic logic [0:6] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b0000001;
         4'h1: seg7 = 7'b1001111;
         4'h2: seg7 = 7'b0010010;
         4'h3: seg7 = 7'b0000110;
         4'h4: seg7 = 7'b1001100;
         4'h5: seg7 = 7'b0100100;
         4'h6: seg7 = 7'b0100000;
         4'h7: seg7 = 7'b0001111;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0000100;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b1100000;
         4'hC: seg7 = 7'b0110001;
         4'hD: seg7 = 7'b1000010;
         4'hE: seg7 = 7'b0110000;
         default: seg7 = 7'b0111000;
      endcase
   endfunction

   // Index 0 = write key, index 1 = read key.
   logic [1:0]       key_raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       level;
   logic [1:0]       level_d;
   logic [CNT_W-1:0] cnt [2];
   logic [1:0]       press;

   state_t state, state_nxt;
   logic   busy, done, we, latch_wr, latch_rd, chk, rd_fin;

   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    data_q;
   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic [DATA_WIDTH-1:0]    q;
   logic [DATA_WIDTH-1:0]    data_out_q;
   logic                     wr_err_q;
   logic [7:0]               wr_count_q;

   assign key_raw = {bus.rd_key_n, bus.wr_key_n};

   // ---- key conditioning: 2-FF sync, then debounce ----
   // The counter only runs while the synced level differs from the accepted
   // level; any return to the accepted level (i.e. any bounce) clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 2'b11;
         sync2   <= 2'b11;
         level   <= 2'b11;
         level_d <= 2'b11;
         for (int k = 0; k < 2; k++) cnt[k] <= '0;
      end else begin
         sync1   <= key_raw;
         sync2   <= sync1;
         level_d <= level;
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] != level[k]) begin
               if (cnt[k] == CNT_LAST) begin
                  level[k] <= sync2[k];
                  cnt[k]   <= '0;
               end else begin
                  cnt[k] <= cnt[k] + 1'b1;
               end
            end else begin
               cnt[k] <= '0;
            end
         end
      end
   end

   // Falling edge of the accepted level only; release is silent.
   assign press = level_d & ~level;

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (press[0])      state_nxt = WRITE;
            else if (press[1]) state_nxt = READ;
         end
         WRITE:     state_nxt = RB_ADDR;
         RB_ADDR:   state_nxt = RB_CHECK;
         RB_CHECK:  state_nxt = IDLE;
         READ:      state_nxt = READ_WAIT;
         READ_WAIT: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   // rst gates we and done so a write caught by reset never reaches the RAM.
   always_comb begin
      busy     = (state != IDLE);
      done     = !rst && ((state == RB_CHECK) || (state == READ_WAIT));
      we       = !rst && (state == WRITE) && !bus.wr_inhibit;
      latch_wr = (state == IDLE) && press[0];
      latch_rd = (state == IDLE) && press[1] && !press[0];
      chk      = (state == RB_CHECK);
      rd_fin   = (state == READ_WAIT);
   end

   // ---- operand latch (switches ignored after this cycle) ----
   always_ff @(posedge clk) begin
      if (latch_wr) begin
         addr_q <= bus.addr_in;
         data_q <= bus.data_in;
      end else if (latch_rd) begin
         addr_q <= bus.addr_in;
      end
   end

   // ---- RAM: synchronous write, registered read; not reset ----
   always_ff @(posedge clk) begin
      if (we) mem[addr_q] <= data_q;
      q <= mem[addr_q];
   end

   // ---- result registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= '0;
         wr_err_q   <= 1'b0;
         wr_count_q <= '0;
      end else if (chk) begin
         data_out_q <= q;
         wr_err_q   <= (q != data_q);
         wr_count_q <= wr_count_q + 8'd1;
      end else if (rd_fin) begin
         data_out_q <= q;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.wr_err   = wr_err_q;
   assign bus.wr_count = wr_count_q;
   assign bus.HEX0     = seg7(data_out_q[3:0]);
   assign bus.HEX1     = seg7(data_out_q[7:4]);
   assign bus.HEX2     = seg7(data_out_q[11:8]);
   assign bus.HEX3     = seg7(data_out_q[15:12]);

endmodule

// File: tb/tb_ram_wr_ctrl.sv
module tb_ram_wr_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   ram_wr_ctrl_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5)) bus ();

   ram_wr_ctrl #(
      .DATA_WIDTH(16), .ADDRESS_WIDTH(5), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010,
                          G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100,
                          G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000,
                          G9 = 7'b0000100, GA = 7'b0001000, GB = 7'b1100000,
                          GC = 7'b0110001, GD = 7'b1000010, GE = 7'b0110000,
                          GF = 7'b0111000;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [4:0]  addr;
      logic [15:0] data;
      int          hold;
      logic [15:0] exp_data;
      logic        exp_err;
      logic [7:0]  exp_cnt;
      logic [27:0] exp_hex;   // {HEX3,HEX2,HEX1,HEX0}
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int done_seen = 0;
   int busy_cyc  = 0;

   always @(negedge clk) begin
      if (bus.done) done_seen++;
      if (bus.busy) busy_cyc++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [27:0] hex_now();
      return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
   endfunction

   // Press the selected keys, keep them low until busy (+hold cycles),
   // scramble the switches, then wait until the controller is idle again.
   // Returns at the first idle cycle after completion.
   task automatic do_op(input logic wr, input logic rd, input logic [4:0] a,
                        input logic [15:0] d, input int hold, output int dones);
      int d0;
      int t;
      d0 = done_seen;
      bus.addr_in  = a;
      bus.data_in  = d;
      bus.wr_key_n = ~wr;
      bus.rd_key_n = ~rd;
      t = 0;
      while (!bus.busy && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!bus.busy) check("busy_timeout", 32'd0, 32'd1);
      repeat (hold) @(negedge clk);
      bus.wr_key_n = 1'b1;
      bus.rd_key_n = 1'b1;
      bus.addr_in  = ~a;
      bus.data_in  = ~d;
      t = 0;
      while (bus.busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
      dones = done_seen - d0;
   endtask

   task automatic settle();
      repeat (12) @(negedge clk);
   endtask

   vec_t vecs[9];
   int   dn;
   int   d0, b0;
   logic [7:0] cnt0;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 5'h03, 16'hBEEF, 20, 16'hBEEF, 1'b0, 8'd1, {GB, GE, GE, GF}};
      vecs[1] = '{1'b0, 1'b1, 5'h03, 16'h0000, 0,  16'hBEEF, 1'b0, 8'd1, {GB, GE, GE, GF}};
      vecs[2] = '{1'b1, 1'b0, 5'h01, 16'h0123, 0,  16'h0123, 1'b0, 8'd2, {G0, G1, G2, G3}};
      vecs[3] = '{1'b1, 1'b0, 5'h02, 16'h4567, 0,  16'h4567, 1'b0, 8'd3, {G4, G5, G6, G7}};
      vecs[4] = '{1'b1, 1'b0, 5'h04, 16'h89AB, 0,  16'h89AB, 1'b0, 8'd4, {G8, G9, GA, GB}};
      vecs[5] = '{1'b1, 1'b0, 5'h05, 16'hCDEF, 0,  16'hCDEF, 1'b0, 8'd5, {GC, GD, GE, GF}};
      vecs[6] = '{1'b0, 1'b1, 5'h01, 16'h0000, 0,  16'h0123, 1'b0, 8'd5, {G0, G1, G2, G3}};
      vecs[7] = '{1'b1, 1'b1, 5'h06, 16'hA5C3, 0,  16'hA5C3, 1'b0, 8'd6, {GA, G5, GC, G3}};
      vecs[8] = '{1'b0, 1'b1, 5'h02, 16'h0000, 0,  16'h4567, 1'b0, 8'd6, {G4, G5, G6, G7}};

      bus.wr_key_n   = 1'b1;
      bus.rd_key_n   = 1'b1;
      bus.addr_in    = '0;
      bus.data_in    = '0;
      bus.wr_inhibit = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Reset state
      check("rst_data_out", 32'(bus.data_out), 32'h0);
      check("rst_busy",     32'(bus.busy),     32'h0);
      check("rst_wr_err",   32'(bus.wr_err),   32'h0);
      check("rst_wr_count", 32'(bus.wr_count), 32'h0);
      check("rst_hex",      32'(hex_now()),    32'({G0, G0, G0, G0}));

      // Table-driven writes and reads
      foreach (vecs[i]) begin
         do_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].hold, dn);
         check($sformatf("v%0d_done", i),     32'(dn),           32'd1);
         check($sformatf("v%0d_data", i),     32'(bus.data_out), 32'(vecs[i].exp_data));
         check($sformatf("v%0d_err", i),      32'(bus.wr_err),   32'(vecs[i].exp_err));
         check($sformatf("v%0d_cnt", i),      32'(bus.wr_count), 32'(vecs[i].exp_cnt));
         check($sformatf("v%0d_hex", i),      32'(hex_now()),    32'(vecs[i].exp_hex));
         settle();
      end

      // Plain read of an unwritten address, then back to 0x03
      do_op(1'b0, 1'b1, 5'h07, 16'h0, 0, dn);
      check("rd07_done", 32'(dn), 32'd1);
      check("rd07_cnt",  32'(bus.wr_count), 32'd6);
      settle();
      do_op(1'b0, 1'b1, 5'h03, 16'h0, 0, dn);
      check("rd03_data", 32'(bus.data_out), 32'hBEEF);
      check("rd03_cnt",  32'(bus.wr_count), 32'd6);
      settle();

      // Key bounce: toggles every 2 cycles never stay stable for 4 samples
      d0 = done_seen;
      b0 = busy_cyc;
      for (int k = 0; k < 6; k++) begin
         bus.wr_key_n = k[0];
         repeat (2) @(negedge clk);
      end
      bus.wr_key_n = 1'b1;
      repeat (15) @(negedge clk);
      check("bounce_busy", 32'(busy_cyc - b0),  32'd0);
      check("bounce_done", 32'(done_seen - d0), 32'd0);
      check("bounce_cnt",  32'(bus.wr_count),   32'd6);

      // Write press landing while a read is in progress is dropped
      d0 = done_seen;
      bus.addr_in  = 5'h05;
      bus.data_in  = 16'h1357;
      bus.rd_key_n = 1'b0;
      @(negedge clk);
      bus.wr_key_n = 1'b0;
      repeat (20) @(negedge clk);
      bus.wr_key_n = 1'b1;
      bus.rd_key_n = 1'b1;
      settle();
      check("drop_done", 32'(done_seen - d0), 32'd1);
      check("drop_cnt",  32'(bus.wr_count),   32'd6);
      check("drop_data", 32'(bus.data_out),   32'hCDEF);

      // Reset in the WRITE cycle aborts the write
      do_op(1'b1, 1'b0, 5'h10, 16'h1234, 0, dn);
      check("w10_data", 32'(bus.data_out), 32'h1234);
      check("w10_cnt",  32'(bus.wr_count), 32'd7);
      settle();
      bus.addr_in  = 5'h10;
      bus.data_in  = 16'h5678;
      bus.wr_key_n = 1'b0;
      begin
         int t;
         t = 0;
         while (!bus.busy && t < 40) begin
            @(negedge clk);
            t++;
         end
         if (!bus.busy) check("abort_busy_timeout", 32'd0, 32'd1);
      end
      rst = 1'b1;
      bus.wr_key_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy",  32'(bus.busy),     32'h0);
      check("abort_data",  32'(bus.data_out), 32'h0);
      check("abort_err",   32'(bus.wr_err),   32'h0);
      check("abort_cnt",   32'(bus.wr_count), 32'h0);
      check("abort_hex",   32'(hex_now()),    32'({G0, G0, G0, G0}));
      settle();
      do_op(1'b0, 1'b1, 5'h10, 16'h0, 0, dn);
      check("abort_rd10", 32'(bus.data_out), 32'h1234);
      settle();

      // 256 writes wrap the counter back to 0
      for (int k = 0; k < 256; k++) begin
         do_op(1'b1, 1'b0, k[4:0], 16'(k), 0, dn);
         if (k == 254) check("wrap_cnt255", 32'(bus.wr_count), 32'd255);
         repeat (8) @(negedge clk);
      end
      check("wrap_cnt0", 32'(bus.wr_count), 32'd0);
      settle();

      // Forced mismatch via the write-enable hook
      do_op(1'b1, 1'b0, 5'h0A, 16'h1111, 0, dn);
      check("mm_good_err", 32'(bus.wr_err), 32'd0);
      settle();
      bus.wr_inhibit = 1'b1;
      do_op(1'b1, 1'b0, 5'h0A, 16'h2222, 0, dn);
      bus.wr_inhibit = 1'b0;
      check("mm_err",  32'(bus.wr_err),   32'd1);
      check("mm_data", 32'(bus.data_out), 32'h1111);
      check("mm_cnt",  32'(bus.wr_count), 32'd2);
      settle();
      cnt0 = bus.wr_count;
      do_op(1'b0, 1'b1, 5'h0A, 16'h0, 0, dn);
      check("mm_rd_err", 32'(bus.wr_err),   32'd1);
      check("mm_rd_cnt", 32'(bus.wr_count), 32'(cnt0));
      settle();
      do_op(1'b1, 1'b0, 5'h0A, 16'h3333, 0, dn);
      check("mm_fix_err",  32'(bus.wr_err),   32'd0);
      check("mm_fix_data", 32'(bus.data_out), 32'h3333);
      check("mm_fix_cnt",  32'(bus.wr_count), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
